// File: rtl/mdu_pkg.sv
// Shared types and op encodings for the multi-cycle multiply/divide unit.
// The OP_* constants are the encodings the ControlUnit drives on op.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MULT  = OP_MULT,
    MULTU = OP_MULTU,
    DIV   = OP_DIV,
    DIVU  = OP_DIVU
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DZ
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t op);
    return op[1];
  endfunction

  // Signed variants have a clear low bit (MULT, DIV).
  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and
// for restoring the sign of a finished result.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply and divide with architectural Hi/Lo.
// Shift-add multiply and restoring divide both run on magnitudes, one bit per cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: partial product high half / partial remainder; mq: multiplier / quotient
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             done_q, done_d, dz_q, dz_d;

  mdu_op_t          op_in;
  logic             sgn_in;
  logic [WIDTH-1:0] a_abs, b_abs, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;

  assign op_in  = mdu_op_t'(op);
  assign sgn_in = op_is_signed(op_in);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .neg_i(sgn_in & a[WIDTH-1]), .val_i(a), .val_o(a_abs));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .neg_i(sgn_in & b[WIDTH-1]), .val_i(b), .val_o(b_abs));
  mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg_i(neg_quo_q), .val_i({acc_q, mq_q}), .val_o(prod_fix));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .neg_i(neg_quo_q), .val_i(mq_q), .val_o(quo_fix));
  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i(neg_rem_q), .val_i(acc_q), .val_o(rem_fix));

  assign mul_sum = {1'b0, acc_q} + ({1'b0, opb_q} & {(WIDTH+1){mq_q[0]}});
  assign rem_sh  = {acc_q, mq_q[WIDTH-1]};
  assign div_ge  = rem_sh >= {1'b0, opb_q};
  // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
  assign div_sub = rem_sh[WIDTH-1:0] - opb_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q marks the cycle that reports a result; start is ignored there.
        if (start && !done_q) begin
          div_d     = op_is_div(op_in);
          neg_quo_d = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = sgn_in & a[WIDTH-1];
          acc_d     = '0;
          mq_d      = a_abs;
          opb_d     = b_abs;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = (op_is_div(op_in) && b == '0) ? DZ : RUN;
        end
      end
      RUN: begin
        if (div_q) begin
          acc_d = div_ge ? div_sub : rem_sh[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        hi_d    = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? quo_fix : prod_fix[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      DZ: begin
        done_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8: expectations are
// queued at start and checked (values and latency) when done pulses.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          e0;
    int          lat;
    string       tag;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q32[$];
  exp_t q8[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32));

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: 64-bit arithmetic, SV signed / and % truncate toward zero.
  function automatic logic [63:0] model32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: p = 64'(sx * sy);
      2'b01: p = {32'b0, x} * {32'b0, y};
      2'b10: if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
             else p = {32'(sx % sy), 32'(sx / sy)};
      default: p = {x % y, x / y};
    endcase
    return p;
  endfunction

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (done32) begin
      if (q32.size() == 0) check("unexpected_done32", 64'(done32), 64'(0));
      else begin
        e = q32.pop_front();
        check({e.tag, "_hi"}, 64'(hi32), 64'(e.hi));
        check({e.tag, "_lo"}, 64'(lo32), 64'(e.lo));
        check({e.tag, "_dz"}, 64'(dz32), 64'(e.dz));
        check({e.tag, "_lat"}, 64'(cyc - e.e0), 64'(e.lat));
      end
    end
    if (done8) begin
      if (q8.size() == 0) check("unexpected_done8", 64'(done8), 64'(0));
      else begin
        e = q8.pop_front();
        check({e.tag, "_hi"}, 64'(hi8), 64'(e.hi));
        check({e.tag, "_lo"}, 64'(lo8), 64'(e.lo));
        check({e.tag, "_dz"}, 64'(dz8), 64'(e.dz));
        check({e.tag, "_lat"}, 64'(cyc - e.e0), 64'(e.lat));
      end
    end
  end

  // poke: pulse start (DIVU by zero) mid-operation; must be ignored.
  task automatic go32(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] eh, input logic [31:0] el, input logic ez,
                      input string tag, input bit poke);
    exp_t e;
    int n;
    @(negedge clock);
    op32 = o; a32 = av; b32 = bv; start32 = 1'b1;
    e.hi = eh; e.lo = el; e.dz = ez; e.e0 = cyc + 1; e.lat = ez ? 1 : 33; e.tag = tag;
    q32.push_back(e);
    @(negedge clock);
    start32 = 1'b0; op32 = 2'($urandom); a32 = $urandom; b32 = $urandom;
    if (poke) begin
      repeat (5) @(negedge clock);
      check({tag, "_busy"}, 64'(busy32), 64'(1));
      op32 = 2'b11; b32 = '0; start32 = 1'b1;
      @(negedge clock);
      start32 = 1'b0;
    end
    n = 0;
    while (q32.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_timeout"}, 64'(q32.size()), 64'(0));
  endtask

  task automatic go8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] eh, input logic [7:0] el, input string tag);
    exp_t e;
    int n;
    @(negedge clock);
    op8 = o; a8 = av; b8 = bv; start8 = 1'b1;
    e.hi = 32'(eh); e.lo = 32'(el); e.dz = 1'b0; e.e0 = cyc + 1; e.lat = 9; e.tag = tag;
    q8.push_back(e);
    @(negedge clock);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (q8.size() != 0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_timeout"}, 64'(q8.size()), 64'(0));
  endtask

  initial begin
    logic [63:0] m;
    logic [1:0]  o;
    logic [31:0] x, y;
    reset = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy32), 64'(0));
    check("rst_done", 64'(done32), 64'(0));
    check("rst_dz", 64'(dz32), 64'(0));
    check("rst_hilo", 64'({hi32, lo32}), 64'(0));
    check("rst8_hilo", 64'({busy8, hi8, lo8}), 64'(0));
    reset = 1'b0;

    go32(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "mult_neg", 1'b1);
    go32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max", 1'b0);
    // Still inside the done cycle: this start must be dropped.
    op32 = 2'b11; b32 = '0; start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    @(negedge clock);
    check("done_cycle_start_busy", 64'(busy32), 64'(0));
    go32(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7_2", 1'b0);
    go32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_min_m1", 1'b0);
    go32(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7_m2", 1'b0);
    go32(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_100_7", 1'b0);

    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (o[1]) y = y >> $urandom_range(0, 28);
      if (y == 0) y = 32'd1;
      m = model32(o, x, y);
      go32(o, x, y, m[63:32], m[31:0], 1'b0, "rnd", 1'b0);
    end

    go32(2'b01, 32'h2468_ACF0, 32'h8000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, "preload", 1'b0);
    go32(2'b11, 32'h0000_0007, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b1, "divu_zero", 1'b0);

    // Abort a MULT mid-run; no done may follow and hi/lo must clear.
    @(negedge clock);
    op32 = 2'b00; a32 = 32'h0000_1234; b32 = 32'h0000_5678; start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 64'(busy32), 64'(0));
    check("abort_done", 64'(done32), 64'(0));
    check("abort_hilo", 64'({hi32, lo32}), 64'(0));
    repeat (40) @(negedge clock);
    go32(2'b01, 32'd3, 32'd4, 32'd0, 32'h0000_000C, 1'b0, "multu_3_4", 1'b0);

    go8(2'b00, 8'h80, 8'h80, 8'h40, 8'h00, "w8_mult_min");
    go8(2'b11, 8'hFF, 8'h10, 8'h0F, 8'h0F, "w8_divu");
    go8(2'b00, 8'h7F, 8'h80, 8'hC0, 8'h80, "w8_mult_mix");
    go8(2'b10, 8'h80, 8'hFF, 8'h00, 8'h80, "w8_div_min_m1");

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
